cpu_trace_tx: RTL and testbench
===============================

# cpu_trace_tx

Pipeline trace transmitter for the 16-bit pipelined CPU. Each enabled clock it captures a snapshot of the CPU's architectural progress: cycle count, IF PC, ID instruction, write-back register/data, and hazard/halt flags. It buffers the snapshots in a record FIFO and streams them out as 8-byte records over a byte-wide valid/ready interface. It sits beside the CPU core and is the on-chip source of the per-cycle trace that benches and lab hardware consume, instead of probing core internals hierarchically.

## Interface
- DEPTH_LOG2, 3, log2 of FIFO depth in records (depth = 8 by default).
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- capture_enable  in  1  capture a record at this edge when high.
- if_pc  in  16  PC presented by IF.
- id_instruction  in  16  instruction in ID.
- wb_write_reg  in  4  write-back destination register.
- wb_write_data  in  16  write-back data.
- wb_reg_write  in  1  write-back enable.
- pc_stop  in  1  hazard-unit PC stall.
- id_flush  in  1  hazard-unit ID flush.
- halt  in  1  CPU halt indication.
- tx_ready  in  1  downstream accepts tx_data this edge.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_data  out  8  trace byte.
- fifo_count  out  DEPTH_LOG2+1  records held, not counting the record being sent.
- overflow  out  1  sticky: a record was dropped.
- drop_count  out  8  dropped records, saturating at 255.
- halted  out  1  sticky: halt captured; capture disabled.

## Operation
- cycle_ctr: 16-bit, increments every clock after reset deasserts, wraps 0xFFFF->0x0000.
- Capture at an edge when capture_enable=1 and halted=0. The record is bytes 0..7:
  - byte 0: cycle_ctr[7:0], the value before the increment.
  - bytes 1-2: if_pc[15:8], if_pc[7:0].
  - bytes 3-4: id_instruction[15:8], id_instruction[7:0].
  - byte 5: {wb_reg_write, pc_stop, id_flush, halt, wb_write_reg[3:0]}.
  - bytes 6-7: wb_write_data[15:8], wb_write_data[7:0].
- Push is accepted if fifo_count < 2^DEPTH_LOG2, or if a pop occurs at the same edge.
- Otherwise the record is dropped: overflow<=1 and drop_count increments (saturating).
- halt=1 in a captured record sets halted. That record is stored, and no further captures occur until reset. Already-buffered records still drain.
- Serializer FSM:
  - IDLE: tx_valid=0. When the FIFO is non-empty, load the head record and go to SEND with index 0.
  - SEND: tx_data = record byte[index]. On tx_valid && tx_ready, index++.
  - On acceptance of byte 7: if the FIFO is non-empty, load the next record and stay in SEND with index 0 (no bubble). Otherwise go to IDLE.
  - The head record is popped from the FIFO when it is loaded into the serializer.
- Handshake: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops mid-record except on reset.
- Reset (any time, including mid-record): the FIFO empties and the partial record is discarded.
  - Reset values: all outputs 0, FSM to IDLE, cycle_ctr=0, index=0, overflow=0, drop_count=0, halted=0.

## Timing
- tx_valid and tx_data are registered outputs.
- Capture at edge k into an empty FIFO with the FSM in IDLE: the record loads at edge k+1, and tx_valid=1 with byte 0 is visible after edge k+1. Latency is 1 cycle.
- With tx_ready held high, one record takes 8 cycles. Sustained throughput is one record per 8 cycles, so continuous capture overflows unless capture_enable is duty-cycled.
- fifo_count updates at the edge of push/pop. A simultaneous push and pop leaves it unchanged.
- Asynchronous reset assertion forces tx_valid=0 immediately, without waiting for a clock edge.

## Test plan
- Single record, no backpressure:
  - Stimulus: release reset, tx_ready=1. Capture once at cycle_ctr=0x05 with if_pc=0x0010, id_instruction=0x1234, wb_reg_write=1, wb_write_reg=3, wb_write_data=0xBEEF, other flags 0.
  - Required response: bytes 05 00 10 12 34 83 BE EF on 8 consecutive cycles, then tx_valid=0.
- Backpressure:
  - Stimulus: same record; drop tx_ready low for 3 cycles while byte 2 is presented.
  - Required response: tx_data=0x10 and tx_valid=1 held for those 3 cycles; the byte sequence is unchanged.
- Overflow:
  - Stimulus: tx_ready=0, capture_enable=1 for 10 consecutive cycles from reset.
  - Required response: after the first record loads into the serializer, 8 records fill the FIFO. fifo_count=8, drop_count=1, overflow=1.
  - Then raise tx_ready. The 9 records drain in order, with byte 0 values 00,01,...,08 (no bubble between records), and capture 09 is absent.
- Halt:
  - Stimulus: capture 3 records, the second with halt=1.
  - Required response: exactly 2 records are emitted, the second with byte5 bit4=1. halted=1, and the third capture is ignored.
- Reset mid-record:
  - Stimulus: assert reset while byte 4 is presented.
  - Required response: tx_valid=0 immediately; fifo_count=0, drop_count=0, overflow=0.
  - After release, a new capture emits byte 0 = 0x00.
- Counter wrap:
  - Stimulus: run 256 cycles without capture, then capture.
  - Required response: byte 0 = 0x00, reflecting the cycle_ctr[7:0] wrap.

Source files
------------

// File: rtl/cpu_trace_tx_if.sv
// Byte-wide valid/ready stream carrying serialized trace records.
interface cpu_trace_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/cpu_trace_tx.sv
// Pipeline trace transmitter: captures per-cycle CPU snapshots into a record
// FIFO and streams them out as 8-byte records over a byte-wide valid/ready port.
module cpu_trace_tx #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture_enable,
    input  logic [15:0]           if_pc,
    input  logic [15:0]           id_instruction,
    input  logic [3:0]            wb_write_reg,
    input  logic [15:0]           wb_write_data,
    input  logic                  wb_reg_write,
    input  logic                  pc_stop,
    input  logic                  id_flush,
    input  logic                  halt,
    cpu_trace_tx_if.master        tx,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    output logic                  halted
);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                state_q, state_d;
    logic [2:0]            index_q, index_d;
    logic [63:0]           shift_q, shift_d;
    logic [15:0]           cycle_ctr_q, cycle_ctr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;
    logic                  halted_q, halted_d;
    logic [63:0]           mem_q [1 << DEPTH_LOG2];

    logic [63:0] record;
    logic        capture;
    logic        push;
    logic        pop;
    logic        drop;
    logic        byte_accept;
    logic        last_byte;

    // Capture, FIFO bookkeeping and sticky status
    always_comb begin
        record = {cycle_ctr_q[7:0], if_pc, id_instruction,
                  wb_reg_write, pc_stop, id_flush, halt, wb_write_reg,
                  wb_write_data};
        capture     = capture_enable && !halted_q;
        byte_accept = (state_q == S_SEND) && tx.tx_ready;
        last_byte   = byte_accept && (index_q == 3'd7);
        // The serializer pulls the head record whenever it is free to start one
        pop  = (count_q != '0) && ((state_q == S_IDLE) || last_byte);
        push = capture && ((count_q != FULL_COUNT) || pop);
        drop = capture && !push;

        cycle_ctr_d = cycle_ctr_q + 16'd1;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d   = overflow_q || drop;
        drop_count_d = (drop && (drop_count_q != 8'hFF)) ? drop_count_q + 8'd1 : drop_count_q;
        halted_d     = halted_q || (capture && halt);
    end

    // Serializer: shift register presents byte 0 first, index tracks position
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SEND;
                    index_d = 3'd0;
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            S_SEND: begin
                if (last_byte) begin
                    index_d = 3'd0;
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                        shift_d = '0;
                    end
                end else if (byte_accept) begin
                    index_d = index_q + 3'd1;
                    shift_d = {shift_q[55:0], 8'h00};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            shift_q      <= '0;
            cycle_ctr_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            shift_q      <= shift_d;
            cycle_ctr_q  <= cycle_ctr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            halted_q     <= halted_d;
        end
    end

    // Record storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= record;
        end
    end

    assign tx.tx_valid = (state_q == S_SEND);
    assign tx.tx_data  = shift_q[63:56];
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_cpu_trace_tx.sv
// Self-checking bench for cpu_trace_tx: directed test-plan scenarios plus a
// randomized phase, checked against a record-queue model of the trace stream.
module tb_cpu_trace_tx;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        capture_enable = 1'b0;
    logic [15:0] if_pc = '0;
    logic [15:0] id_instruction = '0;
    logic [3:0]  wb_write_reg = '0;
    logic [15:0] wb_write_data = '0;
    logic        wb_reg_write = 1'b0;
    logic        pc_stop = 1'b0;
    logic        id_flush = 1'b0;
    logic        halt = 1'b0;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        halted;

    cpu_trace_tx_if tx_bus ();

    cpu_trace_tx #(.DEPTH_LOG2(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .capture_enable (capture_enable),
        .if_pc          (if_pc),
        .id_instruction (id_instruction),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .wb_reg_write   (wb_reg_write),
        .pc_stop        (pc_stop),
        .id_flush       (id_flush),
        .halt           (halt),
        .tx             (tx_bus),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int unsigned m_cycle = 0;
    bit          m_halted = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  golden [8] = '{8'h05, 8'h00, 8'h10, 8'h12, 8'h34, 8'h83, 8'hBE, 8'hEF};

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic cap, input logic [15:0] pc, input logic [15:0] instr,
                                  input logic [3:0] wreg, input logic [15:0] wdata, input logic we,
                                  input logic stop, input logic flush, input logic h);
        capture_enable = cap;
        if_pc          = pc;
        id_instruction = instr;
        wb_write_reg   = wreg;
        wb_write_data  = wdata;
        wb_reg_write   = we;
        pc_stop        = stop;
        id_flush       = flush;
        halt           = h;
    endtask

    task automatic apply_random_record(input logic h);
        apply_stimulus(1'b1, 16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom), h);
    endtask

    // One clock: log the byte handshaked at the coming edge and model the capture
    task automatic tick();
        if (prev_stall) begin
            check_output("hold_valid", tx_bus.tx_valid, 1);
            check_output("hold_data", tx_bus.tx_data, prev_data);
        end
        prev_stall = tx_bus.tx_valid && !tx_bus.tx_ready;
        prev_data  = tx_bus.tx_data;
        if (tx_bus.tx_valid && tx_bus.tx_ready) got_q.push_back(tx_bus.tx_data);
        if (capture_enable && !m_halted) begin
            exp_q.push_back(m_cycle[7:0]);
            exp_q.push_back(if_pc[15:8]);
            exp_q.push_back(if_pc[7:0]);
            exp_q.push_back(id_instruction[15:8]);
            exp_q.push_back(id_instruction[7:0]);
            exp_q.push_back({wb_reg_write, pc_stop, id_flush, halt, wb_write_reg});
            exp_q.push_back(wb_write_data[15:8]);
            exp_q.push_back(wb_write_data[7:0]);
            if (halt) m_halted = 1'b1;
        end
        m_cycle++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        capture_enable = 1'b0;
        halt = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_cycle = 0;
        m_halted = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_stream(input string tag);
        int n;
        check_output({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output({tag, "_byte"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tx_bus.tx_ready = 1'b0;

        // Reset state, then a single record with no backpressure
        do_reset();
        check_output("rst_valid", tx_bus.tx_valid, 0);
        check_output("rst_data", tx_bus.tx_data, 0);
        check_output("rst_count", fifo_count, 0);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_drops", drop_count, 0);
        check_output("rst_halted", halted, 0);
        tx_bus.tx_ready = 1'b1;
        repeat (5) tick();
        apply_stimulus(1'b1, 16'h0010, 16'h1234, 4'd3, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        capture_enable = 1'b0;
        check_output("lat_valid", tx_bus.tx_valid, 0);
        check_output("lat_count", fifo_count, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_output("single_valid", tx_bus.tx_valid, 1);
            check_output("single_byte", tx_bus.tx_data, golden[i]);
            tick();
        end
        check_output("single_end_valid", tx_bus.tx_valid, 0);
        check_stream("single");

        // Backpressure while byte 2 is presented
        do_reset();
        tx_bus.tx_ready = 1'b1;
        repeat (5) tick();
        apply_stimulus(1'b1, 16'h0010, 16'h1234, 4'd3, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        capture_enable = 1'b0;
        repeat (3) tick();
        check_output("bp_byte2", tx_bus.tx_data, 8'h10);
        tx_bus.tx_ready = 1'b0;
        repeat (3) begin
            check_output("bp_valid", tx_bus.tx_valid, 1);
            check_output("bp_data", tx_bus.tx_data, 8'h10);
            tick();
        end
        check_output("bp_data_after", tx_bus.tx_data, 8'h10);
        tx_bus.tx_ready = 1'b1;
        repeat (8) tick();
        check_stream("bp");

        // Overflow: ten back-to-back captures with the sink stalled
        do_reset();
        tx_bus.tx_ready = 1'b0;
        repeat (10) begin
            apply_random_record(1'b0);
            tick();
        end
        capture_enable = 1'b0;
        check_output("ovf_count", fifo_count, 8);
        check_output("ovf_drops", drop_count, 1);
        check_output("ovf_flag", overflow, 1);
        check_output("ovf_head", tx_bus.tx_data, 8'h00);
        repeat (8) void'(exp_q.pop_back());
        tx_bus.tx_ready = 1'b1;
        repeat (72) begin
            check_output("ovf_no_bubble", tx_bus.tx_valid, 1);
            tick();
        end
        check_output("ovf_done_valid", tx_bus.tx_valid, 0);
        check_output("ovf_done_count", fifo_count, 0);
        check_stream("ovf");

        // Halt: second record carries halt, third capture must be ignored
        do_reset();
        tx_bus.tx_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            apply_random_record(r == 1);
            tick();
            capture_enable = 1'b0;
            halt = 1'b0;
            repeat (12) tick();
        end
        check_output("halt_sticky", halted, 1);
        check_output("halt_rec_count", got_q.size(), 16);
        check_output("halt_byte5_bit4", got_q[13][4], 1);
        check_stream("halt");

        // Asynchronous reset while byte 4 of a record is presented
        do_reset();
        tx_bus.tx_ready = 1'b0;
        repeat (10) begin
            apply_random_record(1'b0);
            tick();
        end
        capture_enable = 1'b0;
        tx_bus.tx_ready = 1'b1;
        repeat (4) tick();
        check_output("mid_byte4", tx_bus.tx_data, exp_q[4]);
        #2 reset = 1'b0;
        #1;
        check_output("mid_rst_valid", tx_bus.tx_valid, 0);
        check_output("mid_rst_count", fifo_count, 0);
        check_output("mid_rst_drops", drop_count, 0);
        check_output("mid_rst_overflow", overflow, 0);
        @(negedge clock);
        reset = 1'b1;
        m_cycle = 0;
        m_halted = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        got_q.delete();
        apply_random_record(1'b0);
        tick();
        capture_enable = 1'b0;
        tick();
        check_output("mid_new_byte0", tx_bus.tx_data, 8'h00);
        repeat (8) tick();
        check_stream("mid");

        // Counter wrap of the low byte after 256 idle cycles
        do_reset();
        tx_bus.tx_ready = 1'b1;
        repeat (256) tick();
        apply_random_record(1'b0);
        tick();
        capture_enable = 1'b0;
        tick();
        check_output("wrap_byte0", tx_bus.tx_data, 8'h00);
        repeat (8) tick();
        check_stream("wrap");

        // Randomized traffic: sparse captures, random sink backpressure
        do_reset();
        begin
            int gap = 0;
            for (int c = 0; c < 600; c++) begin
                tx_bus.tx_ready = ($urandom_range(0, 3) != 0);
                if (gap >= 24 && $urandom_range(0, 3) == 0) begin
                    apply_random_record(1'b0);
                    gap = 0;
                end else begin
                    capture_enable = 1'b0;
                    gap++;
                end
                tick();
            end
        end
        capture_enable = 1'b0;
        tx_bus.tx_ready = 1'b1;
        repeat (60) tick();
        check_output("rand_drops", drop_count, 0);
        check_output("rand_overflow", overflow, 0);
        check_output("rand_idle", tx_bus.tx_valid, 0);
        check_stream("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
